// File: rtl/gf_mul_32_mac.sv
// gf_mul_32_mac: pipelined GF(2^32) inner-product MAC. GF(2^32) is built as GF(2^16)[X]/(X^2 + X + c).
//   Ports: i_clk, i_rst (sync, active-high), i_start/i_len start a vector of i_len pairs,
//   i_valid/o_ready handshake the (i_x, i_y) pairs, o_o is the accumulated inner product,
//   o_done pulses at completion and o_busy covers the operation through the o_done cycle.
//   Optional macro GF_MUL_32_MAC_OUT_REG_EN registers o_o/o_done once more (+1 cycle latency).

// gf_mul_16: GF(2^16) multiplier (poly x^16+x^5+x^3+x^2+1), LAT register stages on the output (LAT >= 1).
module gf_mul_16 #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] p_o
);
  localparam logic [15:0] POLY = 16'h002D;
  logic [15:0] p, s;
  logic [15:0] pipe_q [LAT];
  always_comb begin
    p = '0;
    s = a_i;
    for (int i = 0; i < 16; i++) begin
      p = b_i[i] ? p ^ s : p;
      s = s[15] ? {s[14:0], 1'b0} ^ POLY : {s[14:0], 1'b0};
    end
  end
  always_ff @(posedge clk) begin
    pipe_q[0] <= p;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign p_o = pipe_q[LAT-1];
endmodule

module gf_mul_32_mac #(
  parameter int          LEN_W     = 8,
  parameter int          MUL16_LAT = 2,
  parameter logic [31:0] IRRED_CST = 32'h2000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_x,
  input  logic [31:0]      i_y,
  output logic [31:0]      o_o,
  output logic             o_done,
  output logic             o_busy
);
  localparam int P = 2 * MUL16_LAT + 1;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, iss_q, iss_d, ret_q, ret_d;
  logic [31:0] acc_q, acc_d, prod_q;
  logic [P-1:0] vld_q;
  logic [15:0] m00, m01, m10, m11, mc;
  logic [15:0] x0y0_q [MUL16_LAT];
  logic [15:0] a1_q [MUL16_LAT];
  logic accept, retire;

  gf_mul_16 #(.LAT(MUL16_LAT)) u_m00 (.clk(i_clk), .a_i(i_x[15:0]),  .b_i(i_y[15:0]),       .p_o(m00));
  gf_mul_16 #(.LAT(MUL16_LAT)) u_m01 (.clk(i_clk), .a_i(i_x[15:0]),  .b_i(i_y[31:16]),      .p_o(m01));
  gf_mul_16 #(.LAT(MUL16_LAT)) u_m10 (.clk(i_clk), .a_i(i_x[31:16]), .b_i(i_y[15:0]),       .p_o(m10));
  gf_mul_16 #(.LAT(MUL16_LAT)) u_m11 (.clk(i_clk), .a_i(i_x[31:16]), .b_i(i_y[31:16]),      .p_o(m11));
  gf_mul_16 #(.LAT(MUL16_LAT)) u_mc  (.clk(i_clk), .a_i(m11),        .b_i(IRRED_CST[15:0]), .p_o(mc));

  assign o_ready = state_q == LOAD;
  assign accept  = i_valid & o_ready;
  assign retire  = vld_q[P-1];

  // x0y0 and the a1 terms wait MUL16_LAT cycles so they meet c*x1y1 at the final XOR stage.
  always_ff @(posedge i_clk) begin
    x0y0_q[0] <= m00;
    a1_q[0]   <= m01 ^ m10 ^ m11;
    for (int i = 1; i < MUL16_LAT; i++) begin
      x0y0_q[i] <= x0y0_q[i-1];
      a1_q[i]   <= a1_q[i-1];
    end
    prod_q <= {a1_q[MUL16_LAT-1], x0y0_q[MUL16_LAT-1] ^ mc};
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    iss_d   = accept ? iss_q + LEN_W'(1) : iss_q;
    ret_d   = retire ? ret_q + LEN_W'(1) : ret_q;
    acc_d   = retire ? acc_q ^ prod_q : acc_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = (i_len == '0) ? DONE : LOAD;
        len_d   = i_len;
        iss_d   = '0;
        ret_d   = '0;
        acc_d   = '0;
      end
      LOAD:    state_d = (accept && iss_d == len_q) ? DRAIN : LOAD;
      DRAIN:   state_d = (ret_q == len_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      acc_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      acc_q   <= acc_d;
      vld_q   <= {vld_q[P-2:0], accept};
    end
  end

`ifdef GF_MUL_32_MAC_OUT_REG_EN
  logic [31:0] o_q;
  logic        done_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q    <= '0;
      done_q <= 1'b0;
    end else begin
      o_q    <= acc_q;
      done_q <= state_q == DONE;
    end
  end
  assign o_o    = o_q;
  assign o_done = done_q;
  assign o_busy = state_q != IDLE || done_q;
`else
  assign o_o    = acc_q;
  assign o_done = state_q == DONE;
  assign o_busy = state_q != IDLE;
`endif
endmodule
